// File: rtl/seg_bcd_if.sv
// Handshake and display bundle between a value producer and seg_bcd_encoder.
interface seg_bcd_if #(
  parameter int WIDTH = 7
);
  logic             in_valid;
  logic [WIDTH-1:0] in_value;
  logic             in_ready;
  logic [13:0]      both7seg;
  logic             out_valid;
  logic             busy;

  modport master (
    output in_valid, in_value,
    input  in_ready, both7seg, out_valid, busy
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, both7seg, out_valid, busy
  );
endinterface

// File: rtl/seg_bcd_encoder.sv
// Binary to two-digit seven-segment encoder using iterative double-dabble.
// Optional macro SEG_BLANK_LEAD_ZERO_EN blanks a leading zero in the tens digit.
module seg_bcd_encoder #(
  parameter int WIDTH          = 7,
  parameter bit ACTIVE_LOW_SEG = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  seg_bcd_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    ENCODE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  localparam logic [13:0] SEG_RESET = ACTIVE_LOW_SEG ? 14'h3FFF : 14'h0000;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] shift_p0;
  logic [7:0]       bcd_p0;
  logic [7:0]       bcd_adj;
  logic             ovf_p0;
  logic [13:0]      seg_p1;
  logic [13:0]      seg_out;
  logic             vld_p2;

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] polarity(input logic [6:0] s);
    return ACTIVE_LOW_SEG ? ~s : s;
  endfunction

  function automatic logic [13:0] encode_pair(input logic [7:0] bcd, input logic ovf);
    logic [6:0] tens;
    logic [6:0] units;
    if (ovf) begin
      tens  = 7'h40;
      units = 7'h40;
    end else begin
      tens  = digit_seg(bcd[7:4]);
      units = digit_seg(bcd[3:0]);
`ifdef SEG_BLANK_LEAD_ZERO_EN
      if (bcd[7:4] == 4'd0) tens = 7'h00;
`endif
    end
    return {polarity(tens), polarity(units)};
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV:    if (cnt == 5'(WIDTH - 1)) state_nxt = ENCODE;
      ENCODE:  state_nxt = EMIT;
      EMIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction applied before each shift so every nibble stays a decimal digit.
  always_comb begin
    bcd_adj = bcd_p0;
    if (bcd_p0[3:0] >= 4'd5) bcd_adj[3:0] = bcd_p0[3:0] + 4'd3;
    if (bcd_p0[7:4] >= 4'd5) bcd_adj[7:4] = bcd_p0[7:4] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      seg_out <= SEG_RESET;
      vld_p2  <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p2 <= (state == EMIT);
      if (accept)             cnt <= 5'd0;
      else if (state == CONV) cnt <= cnt + 5'd1;
      if (state == EMIT)      seg_out <= seg_p1;
    end
  end

  // Stage p0: shift/add-3 datapath; stage p1: registered table lookup feeding the output flop.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_p0 <= bus.in_value;
      bcd_p0   <= 8'd0;
      ovf_p0   <= (bus.in_value > WIDTH'(99));
    end else if (state == CONV) begin
      {bcd_p0, shift_p0} <= {bcd_adj, shift_p0} << 1;
    end
    if (state == ENCODE) seg_p1 <= encode_pair(bcd_p0, ovf_p0);
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.both7seg  = seg_out;
  assign bus.out_valid = vld_p2;

endmodule

// File: tb/tb_seg_bcd_encoder.sv
// Scoreboard bench for seg_bcd_encoder at WIDTH=7, active-high segments.
module tb_seg_bcd_encoder;
  localparam int WIDTH = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_bcd_if #(.WIDTH(WIDTH)) bus ();

  seg_bcd_encoder #(.WIDTH(WIDTH), .ACTIVE_LOW_SEG(1'b0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests  = 0;
  int failed = 0;
  logic [13:0] sb[$];

  function automatic logic [6:0] ref_digit(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] ref_pattern(input int v);
    logic [6:0] t;
    if (v > 99) return {7'h40, 7'h40};
    t = ref_digit(v / 10);
`ifdef SEG_BLANK_LEAD_ZERO_EN
    if (v < 10) t = 7'h00;
`endif
    return {t, ref_digit(v % 10)};
  endfunction

  task automatic send(input int v);
    int guard = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL send_ready value=%0d in_ready=%b required=1", v, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_value = WIDTH'(v);
    sb.push_back(ref_pattern(v));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Starts #1 after an edge with 'elapsed' edges already past the accepting edge.
  task automatic wait_output(input string name, input int elapsed);
    int n = elapsed;
    logic ready_leak = 1'b0;
    logic [13:0] exp;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0) ready_leak = 1'b1;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 14'h0000;
    tests++;
    if (bus.out_valid !== 1'b1 || n != 9) begin
      failed++;
      $display("FAIL %s_latency edges=%0d out_valid=%b required 9 edges with out_valid=1", name, n, bus.out_valid);
    end
    tests++;
    if (bus.both7seg !== exp) begin
      failed++;
      $display("FAIL %s_pattern got=%h required=%h", name, bus.both7seg, exp);
    end
    tests++;
    if (ready_leak || bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s_ready in_ready=%b leak=%b required in_ready=1 leak=0", name, bus.in_ready, ready_leak);
    end
  endtask

  task automatic check_hold(input string name, input logic [13:0] exp);
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.both7seg !== exp) begin
        failed++;
        $display("FAIL %s_hold out_valid=%b pattern=%h required 0 and %h", name, bus.out_valid, bus.both7seg, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    #1;
    tests++;
    if (bus.both7seg !== 14'h0000 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_state seg=%h rdy=%b vld=%b busy=%b required 0000/1/0/0",
               bus.both7seg, bus.in_ready, bus.out_valid, bus.busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.both7seg !== 14'h0000 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_idle seg=%h vld=%b rdy=%b required 0000/0/1", bus.both7seg, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_convert();
    send(42);
    wait_output("v42", 0);
    check_hold("v42", ref_pattern(42));
    send(7);
    wait_output("v7", 0);
    check_hold("v7", ref_pattern(7));
  endtask

  task automatic test_boundary();
    send(99);
    wait_output("v99", 0);
    send(100);
    wait_output("v100", 0);
    send(127);
    wait_output("v127", 0);
    send(0);
    wait_output("v0", 0);
  endtask

  task automatic test_back_to_back();
    send(99);
    wait_output("again99_a", 0);
    send(99);
    wait_output("again99_b", 0);
    send(10);
    wait_output("v10", 0);
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    send(42);
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_value = WIDTH'(13);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_output("ignore13", 4);
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || sb.size() != 0 || bus.both7seg !== ref_pattern(42)) begin
      failed++;
      $display("FAIL ignore_extra pulses=%0d pending=%0d seg=%h required 0/0/%h",
               pulses, sb.size(), bus.both7seg, ref_pattern(42));
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    send(55);
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (bus.both7seg !== 14'h0000 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_mid seg=%h vld=%b rdy=%b required 0000/0/1", bus.both7seg, bus.out_valid, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || bus.both7seg !== 14'h0000) begin
      failed++;
      $display("FAIL reset_mid_quiet pulses=%0d seg=%h required 0/0000", pulses, bus.both7seg);
    end
    send(8);
    wait_output("v8", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_convert();
    test_boundary();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
